datapath: RTL and testbench
===========================

# datapath

Multicycle 16-bit RISC datapath: PC, instruction register, 8x16 register file, ALU with NZC status, 256x16 unified instruction/data memory and pipeline latches. It sits under the external multicycle controller, which drives every select and enable and reads back opcode and flags. A bench back-door port preloads memory.

## Interface
- Parameters: none.
- clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- TBorNot  in  1  1 = bench port owns memory.
- Tb_MEMWE  in  1  bench write enable.
- Tb_MEMAddr  in  8  bench address.
- Tb_MEMData  in  16  bench write data.
- Buff_PC  in  1  PC load enable.
- Branch  in  1  take PC-relative branch (when Jump=00).
- Jump  in  2  next-PC source select.
- Buff_MEMIns  in  1  IR load enable.
- MEMresource  in  1  memory address: 0 = PC, 1 = ALUOut.
- WE_MEM  in  1  memory write enable.
- ALUorNot  in  1  Result source: 0 = ALUOut, 1 = LI/MOV path.
- LIorMOV  in  1  0 = LI value, 1 = A.
- WBresource  in  1  writeback source: 1 = MDR.
- RBresource  in  1  read-port-B address: 0 = IR[4:2], 1 = IR[10:8].
- oprandB  in  1  B latch source: 1 = immediate.
- LI  in  1  0 = LLI form, 1 = LHI form.
- PCplus1orWB  in  1  when WBresource=0: 1 = Result, 0 = PC+1.
- WE_RF  in  1  register file write enable.
- ALUop  in  1  0 = add, 1 = subtract.
- Flag  in  1  include PSW carry (ADC/SBB).
- Buff_PSW  in  1  PSW load enable.
- OutR  out  16  RF[IR[7:5]], combinational.
- PSW_NZC  out  3  {N,Z,C} from the PSW register.
- opcode  out  5  IR[15:11].
- ALUopcode  out  2  IR[1:0].
- OutM  out  16  memory read data.
- OutPC  out  16  PC.
- OutNextPC  out  16  next-PC mux output.

## Operation
- IR fields:
  - Rd = IR[10:8], Rm = IR[7:5], Rn = IR[4:2].
  - imm8 = IR[7:0], imm5 = IR[4:0], imm11 = IR[10:0].
- Every-cycle latches:
  - A <= RF[Rm].
  - B <= oprandB ? zext(imm5) : RF[RBresource ? Rd : Rn].
  - ALUOut <= ALU(A, B).
  - MDR <= memory read data.
  - Result <= ALUorNot ? (LIorMOV ? A : LIval) : ALUOut.
- LIval = LI ? {imm8, B[7:0]} : {8'h00, imm8}.
- Controller contract: every select that a microstep leaves don't-care is held from its first use until the value is consumed.
- ALU:
  - add: A + B + (Flag & C).
  - sub: A - B - (Flag & C).
  - C is carry-out for add and borrow (1 when the unsigned result is negative) for sub.
  - N = result[15]; Z = (result == 0).
- PSW <= {N,Z,C} from the ALU output when Buff_PSW = 1.
- Next PC:
  - Jump 00: Branch ? PC+1+sext(imm8) : PC+1.
  - Jump 01: PC+1+sext(imm11).
  - Jump 10: RF[Rm].
  - Jump 11: RF read port B.
  - All arithmetic is mod 2^16.
- PC <= next PC when Buff_PC = 1.
- IR <= memory read data when Buff_MEMIns = 1.
- Memory:
  - Address = TBorNot ? Tb_MEMAddr : (MEMresource ? ALUOut[7:0] : PC[7:0]).
  - Read is asynchronous.
  - Write is synchronous: Tb_MEMData/Tb_MEMWE when TBorNot = 1, otherwise B/WE_MEM.
- Register file:
  - Two combinational read ports.
  - Write to Rd on the clock edge when WE_RF = 1.
  - Write data = WBresource ? MDR : (PCplus1orWB ? Result : PC+1).
  - A same-cycle read returns the old value.

## Timing
- Async reset (Rst = 0) clears PC, IR, A, B, ALUOut, MDR, Result, PSW and all 8 registers to 0; memory contents are preserved.
- Reset mid-instruction aborts the instruction. After Rst rises, fetch starts at address 0.
- All state updates on the rising edge of clk.
- ALU-type instruction:
  - c1: fetch into IR.
  - c2: A and B latch.
  - c3: ALUOut latches; PSW loads if enabled.
  - c4: Result latches.
  - c5: RF write plus PC update.
  - Data reaches Rd 5 cycles after fetch starts.
- Load:
  - c3: address computed.
  - c4: MDR captures memory[ALUOut].
  - c5: writeback.
- Store: c4 writes B to memory[ALUOut]; B is re-latched with Rd in c3.
- Branch/jump: resolves in c2; a Jump=10/11 target uses the live RF value.

## Test plan
- Preload with TBorNot=1, then reset. LLI R0,#0x0A (0x000A) and LLI R1,#0x05 (0x0105) -> after each 5-cycle sequence, R0=10, R1=5, and PC advances by 1 per instruction.
- OutR with IR[7:5]=0 then 1 -> OutR=0x000A then 0x0005.
- CMP R1,R0 (sub, Buff_PSW in c3) -> PSW_NZC=3'b101; no RF write.
- LHI R2,#0x12 with R2=0x0034 -> R2=0x1234.
- STRri then LDRri round trip at address R3+imm5 -> the loaded value equals the stored value; OutM shows it in c4.
- BEQ taken with Z=1 and offset 0xFE -> PC = PC-1; with Z=0 -> PC = PC+1.
- Assert Rst low during c3 -> PC and PSW become 0 immediately.

Source files
------------

// File: rtl/datapath_if.sv
// Control/status bundle between the multicycle controller (or bench) and the
// datapath, including the memory back-door used for preloading.
interface datapath_if;
   // Memory back-door
   logic        TBorNot;
   logic        Tb_MEMWE;
   logic [7:0]  Tb_MEMAddr;
   logic [15:0] Tb_MEMData;
   // Controller selects and enables
   logic        Buff_PC;
   logic        Branch;
   logic [1:0]  Jump;
   logic        Buff_MEMIns;
   logic        MEMresource;
   logic        WE_MEM;
   logic        ALUorNot;
   logic        LIorMOV;
   logic        WBresource;
   logic        RBresource;
   logic        oprandB;
   logic        LI;
   logic        PCplus1orWB;
   logic        WE_RF;
   logic        ALUop;
   logic        Flag;
   logic        Buff_PSW;
   // Status back to the controller
   logic [15:0] OutR;
   logic [2:0]  PSW_NZC;
   logic [4:0]  opcode;
   logic [1:0]  ALUopcode;
   logic [15:0] OutM;
   logic [15:0] OutPC;
   logic [15:0] OutNextPC;

   modport master (
      output TBorNot, Tb_MEMWE, Tb_MEMAddr, Tb_MEMData,
      output Buff_PC, Branch, Jump, Buff_MEMIns, MEMresource, WE_MEM,
      output ALUorNot, LIorMOV, WBresource, RBresource, oprandB, LI,
      output PCplus1orWB, WE_RF, ALUop, Flag, Buff_PSW,
      input  OutR, PSW_NZC, opcode, ALUopcode, OutM, OutPC, OutNextPC
   );

   modport slave (
      input  TBorNot, Tb_MEMWE, Tb_MEMAddr, Tb_MEMData,
      input  Buff_PC, Branch, Jump, Buff_MEMIns, MEMresource, WE_MEM,
      input  ALUorNot, LIorMOV, WBresource, RBresource, oprandB, LI,
      input  PCplus1orWB, WE_RF, ALUop, Flag, Buff_PSW,
      output OutR, PSW_NZC, opcode, ALUopcode, OutM, OutPC, OutNextPC
   );
endinterface

// File: rtl/datapath.sv
// Multicycle 16-bit RISC datapath: PC, IR, 8x16 register file, add/sub ALU
// with NZC status, 256x16 unified memory and the inter-step latches. All
// sequencing decisions come from the external controller through the bus.
module datapath (
   input logic       clk,
   input logic       Rst,
   datapath_if.slave bus
);

   // Architectural and pipeline state
   logic [15:0] pc_r;
   logic [15:0] ir_r;
   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [15:0] alu_out_r;
   logic [15:0] mdr_r;
   logic [15:0] result_r;
   logic [2:0]  psw_r;
   logic [15:0] rf_r  [0:7];
   logic [15:0] mem_r [0:255];

   // Instruction fields
   logic [2:0]  rd_s;
   logic [2:0]  rm_s;
   logic [2:0]  rn_s;
   logic [7:0]  imm8_s;
   logic [4:0]  imm5_s;
   logic [10:0] imm11_s;

   // Combinational datapath nets
   logic [2:0]  rb_addr_s;
   logic [15:0] rf_a_s;
   logic [15:0] rf_b_s;
   logic [15:0] b_next_s;
   logic [15:0] li_val_s;
   logic [15:0] result_next_s;
   logic        cin_s;
   logic [16:0] alu_wide_s;
   logic [15:0] alu_res_s;
   logic [2:0]  alu_flags_s;
   logic [15:0] pc_plus1_s;
   logic [15:0] next_pc_s;
   logic [7:0]  mem_addr_s;
   logic [15:0] mem_rdata_s;
   logic        mem_we_s;
   logic [15:0] mem_wdata_s;
   logic [15:0] rf_wdata_s;

   assign rd_s    = ir_r[10:8];
   assign rm_s    = ir_r[7:5];
   assign rn_s    = ir_r[4:2];
   assign imm8_s  = ir_r[7:0];
   assign imm5_s  = ir_r[4:0];
   assign imm11_s = ir_r[10:0];

   // Register file read ports; port B doubles as the store-data / LHI source
   assign rb_addr_s = bus.RBresource ? rd_s : rn_s;
   assign rf_a_s    = rf_r[rm_s];
   assign rf_b_s    = rf_r[rb_addr_s];

   assign b_next_s      = bus.oprandB ? {11'd0, imm5_s} : rf_b_s;
   // LHI keeps the low byte of Rd, which B holds after an RBresource=1 read
   assign li_val_s      = bus.LI ? {imm8_s, b_r[7:0]} : {8'h00, imm8_s};
   assign result_next_s = bus.ALUorNot ? (bus.LIorMOV ? a_r : li_val_s) : alu_out_r;

   // ALU: 17-bit arithmetic so bit 16 is carry-out (add) or borrow (sub)
   always_comb begin
      alu_wide_s = 17'd0;
      cin_s      = bus.Flag & psw_r[0];
      if (bus.ALUop) begin
         alu_wide_s = {1'b0, a_r} - {1'b0, b_r} - {16'd0, cin_s};
      end else begin
         alu_wide_s = {1'b0, a_r} + {1'b0, b_r} + {16'd0, cin_s};
      end
   end

   assign alu_res_s   = alu_wide_s[15:0];
   assign alu_flags_s = {alu_res_s[15], (alu_res_s == 16'd0), alu_wide_s[16]};

   assign pc_plus1_s = pc_r + 16'd1;

   // Next-PC selection: sequential/branch, PC-relative jump, register jumps
   always_comb begin
      next_pc_s = pc_plus1_s;
      case (bus.Jump)
         2'b00: begin
            if (bus.Branch) begin
               next_pc_s = pc_plus1_s + {{8{imm8_s[7]}}, imm8_s};
            end else begin
               next_pc_s = pc_plus1_s;
            end
         end
         2'b01:   next_pc_s = pc_plus1_s + {{5{imm11_s[10]}}, imm11_s};
         2'b10:   next_pc_s = rf_a_s;
         2'b11:   next_pc_s = rf_b_s;
         default: next_pc_s = pc_plus1_s;
      endcase
   end

   // Memory port muxing: bench back-door overrides the datapath
   assign mem_addr_s  = bus.TBorNot ? bus.Tb_MEMAddr : (bus.MEMresource ? alu_out_r[7:0] : pc_r[7:0]);
   assign mem_we_s    = bus.TBorNot ? bus.Tb_MEMWE : bus.WE_MEM;
   assign mem_wdata_s = bus.TBorNot ? bus.Tb_MEMData : b_r;
   assign mem_rdata_s = mem_r[mem_addr_s];

   assign rf_wdata_s = bus.WBresource ? mdr_r : (bus.PCplus1orWB ? result_r : pc_plus1_s);

   // Memory array: synchronous write, no reset so preloads survive Rst
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_addr_s] <= mem_wdata_s;
      end
   end

   // Datapath state: latches every cycle, enabled loads, register-file write
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         pc_r      <= 16'd0;
         ir_r      <= 16'd0;
         a_r       <= 16'd0;
         b_r       <= 16'd0;
         alu_out_r <= 16'd0;
         mdr_r     <= 16'd0;
         result_r  <= 16'd0;
         psw_r     <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            rf_r[i] <= 16'd0;
         end
      end else begin
         a_r       <= rf_a_s;
         b_r       <= b_next_s;
         alu_out_r <= alu_res_s;
         mdr_r     <= mem_rdata_s;
         result_r  <= result_next_s;
         if (bus.Buff_PC) begin
            pc_r <= next_pc_s;
         end
         if (bus.Buff_MEMIns) begin
            ir_r <= mem_rdata_s;
         end
         if (bus.Buff_PSW) begin
            psw_r <= alu_flags_s;
         end
         if (bus.WE_RF) begin
            rf_r[rd_s] <= rf_wdata_s;
         end
      end
   end

   assign bus.OutR      = rf_a_s;
   assign bus.PSW_NZC   = psw_r;
   assign bus.opcode    = ir_r[15:11];
   assign bus.ALUopcode = ir_r[1:0];
   assign bus.OutM      = mem_rdata_s;
   assign bus.OutPC     = pc_r;
   assign bus.OutNextPC = next_pc_s;

endmodule

// File: tb/tb_datapath.sv
// Directed bench: acts as the multicycle controller, steps a small program
// through the datapath and compares outputs with hand-computed values.
module tb_datapath;

   logic clk;
   logic Rst;
   int   total;
   int   bad;

   datapath_if bus ();

   datapath dut (
      .clk (clk),
      .Rst (Rst),
      .bus (bus)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.TBorNot     = 1'b0;
      bus.Tb_MEMWE    = 1'b0;
      bus.Buff_PC     = 1'b0;
      bus.Branch      = 1'b0;
      bus.Jump        = 2'b00;
      bus.Buff_MEMIns = 1'b0;
      bus.MEMresource = 1'b0;
      bus.WE_MEM      = 1'b0;
      bus.ALUorNot    = 1'b0;
      bus.LIorMOV     = 1'b0;
      bus.WBresource  = 1'b0;
      bus.RBresource  = 1'b0;
      bus.oprandB     = 1'b0;
      bus.LI          = 1'b0;
      bus.PCplus1orWB = 1'b0;
      bus.WE_RF       = 1'b0;
      bus.ALUop       = 1'b0;
      bus.Flag        = 1'b0;
      bus.Buff_PSW    = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mem_load(input logic [7:0] addr, input logic [15:0] data);
      bus.TBorNot    = 1'b1;
      bus.Tb_MEMWE   = 1'b1;
      bus.Tb_MEMAddr = addr;
      bus.Tb_MEMData = data;
      tick();
      bus.Tb_MEMWE   = 1'b0;
   endtask

   // Observe the next-PC mux with a register-jump select (reads RF combinationally)
   task automatic npc_check(input string tag, input logic [1:0] jmp, input logic rbres, input logic [15:0] exp);
      bus.Jump       = jmp;
      bus.RBresource = rbres;
      #1;
      check_val(tag, bus.OutNextPC, exp);
      bus.Jump       = 2'b00;
      bus.RBresource = 1'b0;
      #1;
   endtask

   task automatic fetch();
      idle();
      bus.Buff_MEMIns = 1'b1;
      tick();
      bus.Buff_MEMIns = 1'b0;
   endtask

   task automatic exec_li(input logic hi);
      fetch();
      bus.RBresource = hi;
      bus.ALUorNot   = 1'b1;
      bus.LI         = hi;
      tick();
      tick();
      tick();
      bus.WE_RF       = 1'b1;
      bus.PCplus1orWB = 1'b1;
      bus.Buff_PC     = 1'b1;
      tick();
      idle();
   endtask

   task automatic exec_alu(input logic sub, input logic cin, input logic wr);
      fetch();
      bus.ALUop = sub;
      bus.Flag  = cin;
      tick();
      bus.Buff_PSW = 1'b1;
      tick();
      bus.Buff_PSW = 1'b0;
      tick();
      bus.WE_RF       = wr;
      bus.PCplus1orWB = 1'b1;
      bus.Buff_PC     = 1'b1;
      tick();
      idle();
   endtask

   task automatic exec_str();
      fetch();
      bus.oprandB = 1'b1;
      tick();
      bus.oprandB    = 1'b0;
      bus.RBresource = 1'b1;
      tick();
      bus.MEMresource = 1'b1;
      bus.WE_MEM      = 1'b1;
      tick();
      idle();
      bus.Buff_PC = 1'b1;
      tick();
      idle();
   endtask

   task automatic exec_ldr(input logic [15:0] exp_m);
      fetch();
      bus.oprandB = 1'b1;
      tick();
      tick();
      bus.MEMresource = 1'b1;
      #1;
      check_val("ldr_outm_c4", bus.OutM, exp_m);
      tick();
      bus.MEMresource = 1'b0;
      bus.WBresource  = 1'b1;
      bus.WE_RF       = 1'b1;
      bus.Buff_PC     = 1'b1;
      tick();
      idle();
   endtask

   task automatic exec_br(input logic take);
      fetch();
      bus.Branch  = take;
      bus.Buff_PC = 1'b1;
      tick();
      idle();
   endtask

   // Directed program and checks
   initial begin
      logic [15:0] prog [0:12];
      total = 0;
      bad   = 0;
      prog[0]  = 16'h000A; // LLI R0,#0x0A
      prog[1]  = 16'h0105; // LLI R1,#0x05
      prog[2]  = 16'h1021; // CMP R1,R0
      prog[3]  = 16'h0234; // LLI R2,#0x34
      prog[4]  = 16'h0A12; // LHI R2,#0x12
      prog[5]  = 16'h0340; // LLI R3,#0x40
      prog[6]  = 16'h1A63; // STR R2,[R3,#3]
      prog[7]  = 16'h2463; // LDR R4,[R3,#3]
      prog[8]  = 16'h3504; // ADC R5,R0,R1
      prog[9]  = 16'h1021; // CMP R1,R0
      prog[10] = 16'h28FE; // BEQ -2 (not taken)
      prog[11] = 16'h1001; // CMP R0,R0
      prog[12] = 16'h28FE; // BEQ -2 (taken)

      Rst = 1'b0;
      idle();
      bus.Tb_MEMAddr = 8'd0;
      bus.Tb_MEMData = 16'd0;
      for (int i = 0; i < 13; i++) begin
         mem_load(i[7:0], prog[i]);
      end
      idle();
      #2;
      Rst = 1'b1;
      tick();

      check_val("rst_pc", bus.OutPC, 16'h0000);
      check_val("rst_psw", {13'd0, bus.PSW_NZC}, 16'h0000);
      check_val("rst_outr", bus.OutR, 16'h0000);

      exec_li(1'b0);
      check_val("lli_r0_outr", bus.OutR, 16'h000A);
      check_val("lli_r0_pc", bus.OutPC, 16'h0001);

      exec_li(1'b0);
      npc_check("lli_r1", 2'b11, 1'b1, 16'h0005);
      check_val("lli_r1_outr_r0", bus.OutR, 16'h000A);
      check_val("lli_r1_pc", bus.OutPC, 16'h0002);

      exec_alu(1'b1, 1'b0, 1'b0);
      check_val("cmp_psw", {13'd0, bus.PSW_NZC}, 16'h0005);
      check_val("cmp_outr_r1", bus.OutR, 16'h0005);
      check_val("cmp_opcode", {11'd0, bus.opcode}, 16'h0002);
      check_val("cmp_aluopc", {14'd0, bus.ALUopcode}, 16'h0001);
      npc_check("cmp_no_wr_r0", 2'b11, 1'b1, 16'h000A);
      check_val("cmp_pc", bus.OutPC, 16'h0003);

      exec_li(1'b0);
      npc_check("lli_r2", 2'b11, 1'b1, 16'h0034);
      exec_li(1'b1);
      npc_check("lhi_r2", 2'b11, 1'b1, 16'h1234);
      check_val("lhi_pc", bus.OutPC, 16'h0005);

      exec_li(1'b0);
      npc_check("lli_r3", 2'b11, 1'b1, 16'h0040);

      exec_str();
      check_val("str_pc", bus.OutPC, 16'h0007);
      exec_ldr(16'h1234);
      npc_check("ldr_r4", 2'b11, 1'b1, 16'h1234);
      npc_check("jr_rm_r3", 2'b10, 1'b0, 16'h0040);
      check_val("ldr_pc", bus.OutPC, 16'h0008);

      exec_alu(1'b0, 1'b1, 1'b1);
      npc_check("adc_r5", 2'b11, 1'b1, 16'h0010);
      check_val("adc_psw", {13'd0, bus.PSW_NZC}, 16'h0000);

      exec_alu(1'b1, 1'b0, 1'b0);
      check_val("cmp2_psw", {13'd0, bus.PSW_NZC}, 16'h0005);
      exec_br(1'b0);
      check_val("beq_not_taken_pc", bus.OutPC, 16'h000B);

      exec_alu(1'b1, 1'b0, 1'b0);
      check_val("cmp_eq_psw", {13'd0, bus.PSW_NZC}, 16'h0002);
      check_val("cmp_eq_pc", bus.OutPC, 16'h000C);
      exec_br(1'b1);
      check_val("beq_taken_pc", bus.OutPC, 16'h000B);

      // Abort an instruction with reset during c3
      fetch();
      bus.ALUop = 1'b1;
      tick();
      bus.Buff_PSW = 1'b1;
      Rst = 1'b0;
      #1;
      check_val("rst_mid_pc", bus.OutPC, 16'h0000);
      check_val("rst_mid_psw", {13'd0, bus.PSW_NZC}, 16'h0000);
      idle();
      #1;
      Rst = 1'b1;
      tick();
      npc_check("rst_rf_cleared", 2'b11, 1'b1, 16'h0000);

      exec_li(1'b0);
      check_val("refetch_r0", bus.OutR, 16'h000A);
      check_val("refetch_pc", bus.OutPC, 16'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
